// File: rtl/cond_branch_unit.sv
// Conditional branch evaluator: snapshots ALU flags on a start request, resolves
// the condition code and the PC-relative target, and reports with a done pulse.
module cond_branch_unit #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [3:0]        cond,
  input  logic [3:0]        status,
  input  logic [ADDR_W-1:0] pc,
  input  logic [OFF_W-1:0]  offset,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              pc_load,
  output logic [ADDR_W-1:0] target,
  output logic              illegal,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        snap_cond;
  logic [3:0]        snap_status;
  logic [ADDR_W-1:0] snap_pc;
  logic [OFF_W-1:0]  snap_offset;
  logic              taken_r;
  logic [ADDR_W-1:0] target_r;
  logic              cond_true;
  logic [ADDR_W-1:0] target_next;

  // Flags are {C,V,N,Z}; condition decode works only on the snapshot.
  function automatic logic eval_cond(input logic [3:0] cc, input logic [3:0] fl);
    logic c, v, n, z;
    c = fl[3];
    v = fl[2];
    n = fl[1];
    z = fl[0];
    case (cc)
      4'h0:    eval_cond = z;
      4'h1:    eval_cond = ~z;
      4'h2:    eval_cond = c;
      4'h3:    eval_cond = ~c;
      4'h4:    eval_cond = n;
      4'h5:    eval_cond = ~n;
      4'h6:    eval_cond = v;
      4'h7:    eval_cond = ~v;
      4'h8:    eval_cond = c & ~z;
      4'h9:    eval_cond = ~c | z;
      4'hA:    eval_cond = (n == v);
      4'hB:    eval_cond = (n != v);
      4'hC:    eval_cond = ~z & (n == v);
      4'hD:    eval_cond = z | (n != v);
      4'hE:    eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  always_comb begin
    cond_true   = eval_cond(snap_cond, snap_status);
    // Target wraps silently modulo 2^ADDR_W.
    target_next = snap_pc + {{(ADDR_W-OFF_W){snap_offset[OFF_W-1]}}, snap_offset};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      snap_cond   <= '0;
      snap_status <= '0;
      snap_pc     <= '0;
      snap_offset <= '0;
      taken_r     <= 1'b0;
      target_r    <= '0;
      taken_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            snap_cond   <= cond;
            snap_status <= status;
            snap_pc     <= pc;
            snap_offset <= offset;
            state       <= EVAL;
          end
        end
        EVAL: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            taken_r  <= cond_true;
            target_r <= target_next;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!flush && taken_r && (taken_cnt != {CNT_W{1'b1}}))
            taken_cnt <= taken_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing in DONE suppresses the strobes in that same cycle.
  assign busy    = (state != IDLE);
  assign done    = (state == DONE) && !flush;
  assign taken   = taken_r;
  assign target  = target_r;
  assign pc_load = done && taken_r;
  assign illegal = done && (snap_cond == 4'hF);

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed bench for cond_branch_unit: condition decode, target arithmetic,
// snapshot/busy behaviour, flush, counter saturation and reset.
module tb_cond_branch_unit;
  localparam int ADDR_W = 16;
  localparam int OFF_W  = 12;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic              flush;
  logic [3:0]        cond;
  logic [3:0]        status;
  logic [ADDR_W-1:0] pc;
  logic [OFF_W-1:0]  offset;
  logic              busy;
  logic              done;
  logic              taken;
  logic              pc_load;
  logic [ADDR_W-1:0] target;
  logic              illegal;
  logic [CNT_W-1:0]  taken_cnt;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  cond_branch_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .cond(cond),
    .status(status), .pc(pc), .offset(offset), .busy(busy), .done(done),
    .taken(taken), .pc_load(pc_load), .target(target), .illegal(illegal),
    .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and leaves the bench one cycle before DONE (in EVAL).
  task automatic issue(input logic [3:0] c, input logic [3:0] s,
                       input logic [ADDR_W-1:0] p, input logic [OFF_W-1:0] o);
    cond = c; status = s; pc = p; offset = o; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; flush = 1'b0;
    cond = 4'h0; status = 4'h1; pc = '0; offset = '0;
    tick(); tick();
    checks++;
    if ({busy, done, taken, pc_load, illegal} !== 5'b0 || target !== 16'h0 || taken_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b taken=%b pc_load=%b illegal=%b target=%h cnt=%h, want all 0",
               busy, done, taken, pc_load, illegal, target, taken_cnt);
    end
    start = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: cycle %0d done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
    exp_cnt = '0;
  endtask

  task automatic test_eq_taken();
    issue(4'h0, 4'b0001, 16'h0100, 12'h010);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL eq_eval_cycle: done=%b busy=%b, want 0 1", done, busy);
    end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (done !== 1'b1 || taken !== 1'b1 || pc_load !== 1'b1 || target !== 16'h0110 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL eq_done: done=%b taken=%b pc_load=%b target=%h illegal=%b, want 1 1 1 0110 0",
               done, taken, pc_load, target, illegal);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pc_load !== 1'b0 || taken !== 1'b1 || taken_cnt !== 8'd1) begin
      errors++;
      $display("FAIL eq_after: done=%b busy=%b pc_load=%b taken=%b cnt=%0d, want 0 0 0 1 1",
               done, busy, pc_load, taken, taken_cnt);
    end
  endtask

  task automatic test_signed();
    issue(4'hA, 4'b0110, 16'h1000, 12'h002);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (done !== 1'b1 || taken !== 1'b1 || target !== 16'h1002) begin
      errors++;
      $display("FAIL signed_ge: done=%b taken=%b target=%h, want 1 1 1002", done, taken, target);
    end
    tick();
    issue(4'hB, 4'b0110, 16'h0200, 12'h7FF);
    tick();
    checks++;
    if (done !== 1'b1 || taken !== 1'b0 || pc_load !== 1'b0 || target !== 16'h09FF) begin
      errors++;
      $display("FAIL signed_lt: done=%b taken=%b pc_load=%b target=%h, want 1 0 0 09ff", done, taken, pc_load, target);
    end
    tick();
    checks++;
    if (taken_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL signed_cnt: cnt=%0d, want %0d", taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap_illegal();
    issue(4'hE, 4'b0000, 16'h0004, 12'hFF8);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (done !== 1'b1 || taken !== 1'b1 || target !== 16'hFFFC || illegal !== 1'b0) begin
      errors++;
      $display("FAIL wrap_al: done=%b taken=%b target=%h illegal=%b, want 1 1 fffc 0", done, taken, target, illegal);
    end
    tick();
    issue(4'hF, 4'b1111, 16'h0004, 12'hFF8);
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL nv_illegal_early: illegal=%b, want 0", illegal);
    end
    tick();
    checks++;
    if (done !== 1'b1 || taken !== 1'b0 || illegal !== 1'b1 || pc_load !== 1'b0 || target !== 16'hFFFC) begin
      errors++;
      $display("FAIL nv_done: done=%b taken=%b illegal=%b pc_load=%b target=%h, want 1 0 1 0 fffc",
               done, taken, illegal, pc_load, target);
    end
    tick();
    checks++;
    if (illegal !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL nv_after: illegal=%b done=%b, want 0 0", illegal, done);
    end
  endtask

  task automatic test_cond_table();
    logic [3:0] tc [12];
    logic [3:0] ts [12];
    logic       te [12];
    // {cond, {C,V,N,Z}, expected taken}
    tc[0]  = 4'h1; ts[0]  = 4'b0001; te[0]  = 1'b0;
    tc[1]  = 4'h2; ts[1]  = 4'b1000; te[1]  = 1'b1;
    tc[2]  = 4'h3; ts[2]  = 4'b1000; te[2]  = 1'b0;
    tc[3]  = 4'h4; ts[3]  = 4'b0010; te[3]  = 1'b1;
    tc[4]  = 4'h5; ts[4]  = 4'b0010; te[4]  = 1'b0;
    tc[5]  = 4'h6; ts[5]  = 4'b0100; te[5]  = 1'b1;
    tc[6]  = 4'h7; ts[6]  = 4'b0100; te[6]  = 1'b0;
    tc[7]  = 4'h8; ts[7]  = 4'b1000; te[7]  = 1'b1;
    tc[8]  = 4'h9; ts[8]  = 4'b1000; te[8]  = 1'b0;
    tc[9]  = 4'hC; ts[9]  = 4'b0000; te[9]  = 1'b1;
    tc[10] = 4'hC; ts[10] = 4'b0100; te[10] = 1'b0;
    tc[11] = 4'hD; ts[11] = 4'b0001; te[11] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(tc[i], ts[i], 16'h2000, 12'h800);
      tick();
      if (te[i]) exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (done !== 1'b1 || taken !== te[i] || target !== 16'h1800) begin
        errors++;
        $display("FAIL cond_%h_status_%b: done=%b taken=%b target=%h, want 1 %b 1800",
                 tc[i], ts[i], done, taken, target, te[i]);
      end
      tick();
    end
    checks++;
    if (taken_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL table_cnt: cnt=%0d, want %0d", taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_snapshot_busy();
    issue(4'h0, 4'b0001, 16'h0300, 12'h001);
    status = 4'b0000; start = 1'b1; pc = 16'h7777;
    tick();
    start = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (done !== 1'b1 || taken !== 1'b1 || target !== 16'h0301) begin
      errors++;
      $display("FAIL snapshot_done: done=%b taken=%b target=%h, want 1 1 0301", done, taken, target);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL snapshot_no_second: cycle %0d done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_flush();
    issue(4'hE, 4'b0000, 16'h0040, 12'h004);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_eval: busy=%b done=%b, want 0 0", busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || taken_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL flush_eval_after: done=%b cnt=%0d, want 0 %0d", done, taken_cnt, exp_cnt);
    end
    issue(4'hE, 4'b0000, 16'h0040, 12'h004);
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || pc_load !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: done=%b pc_load=%b illegal=%b, want 0 0 0", done, pc_load, illegal);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || taken_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL flush_done_cnt: busy=%b cnt=%0d, want 0 %0d", busy, taken_cnt, exp_cnt);
    end
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_wins_idle: busy=%b, want 0", busy);
    end
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 259; i++) begin
      issue(4'hE, 4'b0000, 16'h0000, 12'h001);
      tick();
      tick();
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 1'b1;
    end
    checks++;
    if (taken_cnt !== 8'hFF || exp_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL saturate: cnt=%h model=%h, want ff", taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_midop();
    issue(4'hE, 4'b0000, 16'h0010, 12'h010);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || taken_cnt !== 8'h0 || target !== 16'h0 || taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b cnt=%h target=%h taken=%b, want 0 00 0000 0",
               busy, taken_cnt, target, taken);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop_after: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_eq_taken();
    test_signed();
    test_wrap_illegal();
    test_cond_table();
    test_snapshot_busy();
    test_flush();
    test_saturate();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
Consumer side of the ALU status flags. Takes the 4-bit {C,V,N,Z} status word and a 4-bit condition code on a start request. Evaluates the condition over a fixed multicycle sequence and computes the branch target PC. Returns a one-cycle done pulse with taken/target and a PC-load strobe to the control unit. Keeps a saturating count of taken branches for debug.

Parameters:
ADDR_W, 16, PC/target width in bits.
OFF_W, 12, branch offset width, two's complement, sign-extended to ADDR_W.
CNT_W, 8, width of the taken-branch counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request strobe; accepted only in IDLE.
flush  input  1  synchronous abort of an in-flight evaluation.
cond  input  4  condition code (encoding below).
status  input  4  ALU flags {C,V,N,Z}, bit3=C, bit0=Z.
pc  input  ADDR_W  PC of the branch instruction.
offset  input  OFF_W  signed branch displacement.
busy  output  1  high in EVAL and DONE.
done  output  1  one-cycle result strobe.
taken  output  1  condition result; valid when done=1.
pc_load  output  1  equals done & taken.
target  output  ADDR_W  branch target; valid when done=1.
illegal  output  1  high with done when cond=4'b1111.
taken_cnt  output  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (async, rst=1): state=IDLE. busy, done, taken, pc_load, illegal = 0. target=0. taken_cnt=0. All internal snapshots=0.
- FSM states IDLE, EVAL, DONE.
- IDLE:
  - If start=1 and flush=0: capture cond, status, pc and offset into snapshot registers, then go to EVAL.
  - Otherwise stay in IDLE.
- EVAL: compute cond_true from the snapshot. Compute target_next = pc + sext(offset) mod 2^ADDR_W; wrap-around is silent. Register both and go to DONE.
- DONE: done=1, taken=cond_true, pc_load=cond_true, target valid, illegal=(cond==4'b1111). Next cycle go to IDLE.
- done is asserted exactly 2 cycles after the start-accept edge.
- Outside DONE: done, pc_load and illegal = 0. taken and target hold their last values.
- Condition encoding (snapshot flags):
  - 0 EQ: Z. 1 NE: ~Z.
  - 2 CS: C. 3 CC: ~C.
  - 4 MI: N. 5 PL: ~N.
  - 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: ~Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1.
  - F NV: 0, with illegal=1.
- Flags are snapshotted at accept. Changes on status after accept do not affect the result.
- start while busy is ignored: no queueing, no snapshot overwrite.
- flush=1 in EVAL or DONE: go to IDLE next cycle. done, pc_load and illegal are forced 0 in that cycle. taken_cnt is not incremented.
- flush and start both 1 in IDLE: flush wins, request dropped.
- taken_cnt increments by 1 in each DONE cycle with cond_true=1 and flush=0. It saturates at 2^CNT_W-1.
- rst asserted mid-operation: immediate return to IDLE with all reset values, including taken_cnt=0.

Test Plan:
- Reset: assert rst → all outputs 0 and busy=0. start=1 while rst=1 → no done after release.
- EQ taken: status=4'b0001, cond=0, pc=16'h0100, offset=12'h010, start at cycle 0 → done=1 at cycle 2, taken=1, pc_load=1, target=16'h0110, taken_cnt=1.
- Signed compare: status {C,V,N,Z}=4'b0110 (N=1,V=1), cond=A (GE) → taken=1. Same flags with cond=B (LT) → taken=0, pc_load=0, target still computed.
- Negative offset with wrap: pc=16'h0004, offset=12'hFF8 (-8), cond=E → target=16'hFFFC, taken=1. cond=F → taken=0, illegal=1 for exactly one cycle.
- Snapshot and busy: start with status Z=1, cond=0. Drop Z to 0 and pulse start again during EVAL → single done, taken=1, no second done.
- Flush: start, then flush=1 in EVAL → no done, state back to IDLE, taken_cnt unchanged. Also force 2^CNT_W+3 AL branches → taken_cnt saturates at 8'hFF.
